fifo_word_packer: RTL and testbench

Downstream consumer of the synchronous FIFO. It drains DATA_WIDTH-bit words through the FIFO read port (rd_en/EMPTY/data_out) and packs PACK_RATIO consecutive words into one wide output word. The wide word is delivered over a valid/ready handshake. A flush request emits a partially filled word, so a link can be drained at end of burst.

---
 rtl/fifo_word_packer_if.sv | 39 +++
 rtl/fifo_word_packer.sv | 119 +++++++++++
 tb/tb_fifo_word_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Bus bundle for fifo_word_packer: FIFO read port, flush request and the packed-word
// valid/ready output. master = packer side, slave = FIFO/sink environment side.
interface fifo_word_packer_if #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned PACK_RATIO = 4
);
    localparam int unsigned CNT_W = $clog2(PACK_RATIO) + 1;

    logic                             fifo_empty;
    logic [DATA_WIDTH-1:0]            fifo_data;
    logic                             fifo_rd_en;
    logic                             flush;
    logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
    logic [CNT_W-1:0]                 out_count;
    logic                             out_valid;
    logic                             out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  flush,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_count,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output flush,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_count,
        input  out_valid
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains a synchronous FIFO and packs PACK_RATIO words per output beat (lane 0 = oldest);
// a flush request emits a partially filled beat.
module fifo_word_packer #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned PACK_RATIO = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_word_packer_if.master  bus
);
    localparam int unsigned ACC_W = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned CNT_W = $clog2(PACK_RATIO) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
    localparam logic [CNT_W:0]   LIMIT    = (CNT_W + 1)'(PACK_RATIO);

    typedef enum logic {
        ST_ACC,
        ST_FLUSH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             flush_pend;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] acc_masked;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] acc_cnt_next;
    logic [CNT_W:0]   inflight;
    logic             rd_pend;
    logic             rd_en;
    logic             transfer;

    logic [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_valid_q;

    assign flush_pend     = (state == ST_FLUSH);
    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_valid  = out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Reads are throttled on words already held plus the one still in flight,
    // so a full accumulator never has a pending capture behind it.
    always_comb begin
        state_next = state;
        inflight   = {1'b0, acc_cnt} + (CNT_W + 1)'(rd_pend);
        rd_en      = rst_n & ~bus.fifo_empty & ~flush_pend & ~bus.flush & (inflight < LIMIT);
        transfer   = (~out_valid_q | bus.out_ready) & ~rd_pend &
                     ((acc_cnt == FULL_CNT) | (flush_pend & (acc_cnt != '0)));
        case (state)
            ST_ACC: begin
                if (bus.flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (transfer || (!rd_pend && acc_cnt == '0)) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    always_comb begin
        acc_next     = acc;
        acc_cnt_next = acc_cnt;
        acc_masked   = '0;
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (CNT_W'(i) < acc_cnt) begin
                acc_masked[i*DATA_WIDTH +: DATA_WIDTH] = acc[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (transfer) begin
            acc_next     = '0;
            acc_cnt_next = '0;
        end else if (rd_pend) begin
            for (int unsigned i = 0; i < PACK_RATIO; i++) begin
                if (acc_cnt == CNT_W'(i)) begin
                    acc_next[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_data;
                end
            end
            acc_cnt_next = acc_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            acc_cnt     <= '0;
            rd_pend     <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc     <= acc_next;
            acc_cnt <= acc_cnt_next;
            rd_pend <= rd_en;
            if (transfer) begin
                out_data_q  <= acc_masked;
                out_count_q <= acc_cnt;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: behavioural FIFO, word-order scoreboard,
// and per-scenario tasks with random traffic.
module tb_fifo_word_packer;
    localparam int unsigned DW = 6;
    localparam int unsigned PR = 4;
    localparam int unsigned AW = DW * PR;
    localparam int unsigned CW = $clog2(PR) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural FIFO sharing rst_n: reset discards everything not yet read.
    logic [DW-1:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr        <= wr_ptr;
            bus.fifo_data <= '0;
        end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data <= fifo_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] word_q [$];

    task automatic push(input logic [DW-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        word_q.push_back(w);
    endtask

    // Expected beat: the next n words in read order, word k at bit offset DW*k.
    task automatic build_expected(input int n, output logic [AW-1:0] val);
        logic [AW-1:0] w;
        val = '0;
        for (int k = 0; k < n; k++) begin
            w = AW'(word_q.pop_front());
            val = val + (w << (DW * k));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) push(DW'(k + 1));
        #1;
        vectors++;
        if (bus.fifo_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rd_en_pre_edge: got %b expected 0", bus.fifo_rd_en);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            #1;
            vectors += 4;
            if (bus.fifo_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_rd_en: got %b expected 0", bus.fifo_rd_en);
            end
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
            end
            if (bus.out_data !== '0) begin
                miscompares++;
                $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
            end
            if (bus.out_count !== '0) begin
                miscompares++;
                $display("FAIL reset_out_count: got %0d expected 0", bus.out_count);
            end
        end
        word_q.delete();
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_basic_pack();
        int rd_cnt = 0, valid_cnt = 0, last_rd = -1, first_valid = -1;
        logic [AW-1:0] got_data = '0, exp_data;
        logic [CW-1:0] got_count = '0;
        bus.out_ready = 1'b1;
        push(6'h01); push(6'h02); push(6'h04); push(6'h08);
        build_expected(4, exp_data);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.fifo_rd_en === 1'b1) begin rd_cnt++; last_rd = i; end
            if (bus.out_valid === 1'b1) begin
                if (valid_cnt == 0) begin
                    first_valid = i; got_data = bus.out_data; got_count = bus.out_count;
                end
                valid_cnt++;
            end
            next_cycle();
        end
        #1;
        vectors += 6;
        if (rd_cnt != 4) begin miscompares++; $display("FAIL basic_rd_pulses: got %0d expected 4", rd_cnt); end
        if (valid_cnt != 1) begin miscompares++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cnt); end
        if (got_data !== exp_data) begin miscompares++; $display("FAIL basic_data: got %h expected %h", got_data, exp_data); end
        if (got_count !== CW'(4)) begin miscompares++; $display("FAIL basic_count: got %0d expected 4", got_count); end
        if (first_valid - last_rd != 3) begin
            miscompares++; $display("FAIL basic_latency: got %0d expected 3", first_valid - last_rd);
        end
        if (bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL basic_rd_en_idle: got %b expected 0", bus.fifo_rd_en); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        logic [AW-1:0] exp1, exp2;
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) push(DW'(k));
        build_expected(4, exp1);
        build_expected(4, exp2);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.fifo_rd_en === 1'b1) rd_cnt++;
            if (bus.out_valid === 1'b1) begin
                vectors++;
                if (bus.out_data !== exp1) begin
                    miscompares++; $display("FAIL bp_hold_data: got %h expected %h", bus.out_data, exp1);
                end
            end
            next_cycle();
        end
        #1;
        vectors += 3;
        if (rd_cnt != 8) begin miscompares++; $display("FAIL bp_rd_pulses: got %0d expected 8", rd_cnt); end
        if (bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL bp_rd_en_stall: got %b expected 0", bus.fifo_rd_en); end
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held: got %b expected 1", bus.out_valid); end
        next_cycle();
        bus.out_ready = 1'b1;
        #1;
        next_cycle();
        #1;
        vectors += 3;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_no_bubble: got %b expected 1", bus.out_valid); end
        if (bus.out_data !== exp2) begin miscompares++; $display("FAIL bp_second_data: got %h expected %h", bus.out_data, exp2); end
        if (bus.out_count !== CW'(4)) begin miscompares++; $display("FAIL bp_second_count: got %0d expected 4", bus.out_count); end
        next_cycle();
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b expected 0", bus.out_valid); end
        next_cycle();
    endtask

    task automatic test_partial_flush();
        int valid_cnt = 0;
        logic [AW-1:0] got_data = '0, exp_data;
        logic [CW-1:0] got_count = '0;
        bus.out_ready = 1'b1;
        push(6'h2A); push(6'h15);
        build_expected(2, exp_data);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.out_valid === 1'b1) valid_cnt++;
            next_cycle();
        end
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                if (valid_cnt == 0) begin got_data = bus.out_data; got_count = bus.out_count; end
                valid_cnt++;
            end
            next_cycle();
        end
        vectors += 3;
        if (valid_cnt != 1) begin miscompares++; $display("FAIL flush_valid_cycles: got %0d expected 1", valid_cnt); end
        if (got_data !== exp_data) begin miscompares++; $display("FAIL flush_data: got %h expected %h", got_data, exp_data); end
        if (got_count !== CW'(2)) begin miscompares++; $display("FAIL flush_count: got %0d expected 2", got_count); end
    endtask

    task automatic test_flush_empty();
        int valid_cnt = 0;
        logic [AW-1:0] got_data = '0, exp_data;
        logic [CW-1:0] got_count = '0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++; $display("FAIL flush_empty_valid: got %b expected 0", bus.out_valid);
            end
            next_cycle();
        end
        for (int k = 0; k < 4; k++) push(DW'($urandom));
        build_expected(4, exp_data);
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                if (valid_cnt == 0) begin got_data = bus.out_data; got_count = bus.out_count; end
                valid_cnt++;
            end
            next_cycle();
        end
        vectors += 3;
        if (valid_cnt != 1) begin miscompares++; $display("FAIL flush_empty_after_cycles: got %0d expected 1", valid_cnt); end
        if (got_data !== exp_data) begin miscompares++; $display("FAIL flush_empty_after_data: got %h expected %h", got_data, exp_data); end
        if (got_count !== CW'(4)) begin miscompares++; $display("FAIL flush_empty_after_count: got %0d expected 4", got_count); end
    endtask

    task automatic test_reset_mid_fill();
        int valid_cnt = 0;
        logic [AW-1:0] got_data = '0, exp_data;
        logic [CW-1:0] got_count = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) push(DW'($urandom));
        for (int i = 0; i < 6; i++) next_cycle();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL midrst_rd_en: got %b expected 0", bus.fifo_rd_en); end
        next_cycle();
        rst_n = 1'b1;
        word_q.delete();
        #1;
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_count !== '0) begin miscompares++; $display("FAIL midrst_count: got %0d expected 0", bus.out_count); end
        next_cycle();
        push(6'h01); push(6'h02); push(6'h04); push(6'h08);
        build_expected(4, exp_data);
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                if (valid_cnt == 0) begin got_data = bus.out_data; got_count = bus.out_count; end
                valid_cnt++;
            end
            next_cycle();
        end
        vectors += 3;
        if (valid_cnt != 1) begin miscompares++; $display("FAIL midrst_reload_cycles: got %0d expected 1", valid_cnt); end
        if (got_data !== exp_data) begin miscompares++; $display("FAIL midrst_reload_data: got %h expected %h", got_data, exp_data); end
        if (got_count !== CW'(4)) begin miscompares++; $display("FAIL midrst_reload_count: got %0d expected 4", got_count); end
    endtask

    task automatic test_back_to_back();
        int n_out = 0;
        int valid_at [3];
        logic [AW-1:0] exp_data;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) push(DW'($urandom));
        for (int i = 0; i < 30; i++) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                if (n_out < 3) begin
                    valid_at[n_out] = i;
                    build_expected(4, exp_data);
                    vectors += 2;
                    if (bus.out_data !== exp_data) begin
                        miscompares++; $display("FAIL b2b_data: got %h expected %h", bus.out_data, exp_data);
                    end
                    if (bus.out_count !== CW'(4)) begin
                        miscompares++; $display("FAIL b2b_count: got %0d expected 4", bus.out_count);
                    end
                end
                n_out++;
            end
            next_cycle();
        end
        vectors++;
        if (n_out != 3) begin
            miscompares++; $display("FAIL b2b_beats: got %0d expected 3", n_out);
        end else begin
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (valid_at[k] - valid_at[k-1] != PR + 2) begin
                    miscompares++;
                    $display("FAIL b2b_period: got %0d expected %0d", valid_at[k] - valid_at[k-1], PR + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        int n_out = 0, n_push = 0;
        logic prev_hold = 1'b0;
        logic [AW-1:0] prev_data = '0, exp_data;
        logic [CW-1:0] prev_count = '0;
        for (int i = 0; i < 800 && n_out < 10; i++) begin
            if (n_push < 40 && $urandom_range(0, 1) == 1) begin
                push(DW'($urandom));
                n_push++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_hold) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_count !== prev_count) begin
                    miscompares++;
                    $display("FAIL rand_stable: got v=%b %h/%0d expected v=1 %h/%0d",
                             bus.out_valid, bus.out_data, bus.out_count, prev_data, prev_count);
                end
            end
            prev_hold = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_data = bus.out_data;
            prev_count = bus.out_count;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                vectors++;
                if (word_q.size() < 4) begin
                    miscompares++;
                    $display("FAIL rand_extra_beat: got %h expected no beat", bus.out_data);
                end else begin
                    build_expected(4, exp_data);
                    if (bus.out_data !== exp_data || bus.out_count !== CW'(4)) begin
                        miscompares++;
                        $display("FAIL rand_beat: got %h/%0d expected %h/4", bus.out_data, bus.out_count, exp_data);
                    end
                end
                n_out++;
            end
            next_cycle();
        end
        vectors++;
        if (n_out != 10) begin
            miscompares++; $display("FAIL rand_beat_total: got %0d expected 10", n_out);
        end
        bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_partial_flush();
        test_flush_empty();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
